// File: rtl/relu_stream_engine_if.sv
// Source-read and destination-write ports between the ReLU stream engine and the GBUFFs.
// The engine uses the master modport; the buffer side uses the slave modport.
interface relu_stream_engine_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 64
) ();
    logic              src_ren;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_rdata;
    logic              dst_wen;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst_wdata;
    logic              dst_ready;

    modport master (
        output src_ren,
        output src_addr,
        input  src_rdata,
        output dst_wen,
        output dst_addr,
        output dst_wdata,
        input  dst_ready
    );

    modport slave (
        input  src_ren,
        input  src_addr,
        output src_rdata,
        input  dst_wen,
        input  dst_addr,
        input  dst_wdata,
        output dst_ready
    );
endinterface

// File: rtl/relu_stream_engine.sv
// Streams LEN packed words from a source GBUFF through a registered per-lane activation stage
// into a destination GBUFF. Reads are credit-limited so the skid FIFO can never overflow.
module relu_stream_engine #(
    parameter int unsigned ELEM_W = 16,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned FIFO_D = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W:0]         cfg_len,
    input  logic [ADDR_W-1:0]       cfg_src,
    input  logic [ADDR_W-1:0]       cfg_dst,
    input  logic [1:0]              cfg_mode,
    input  logic [3:0]              cfg_shift,
    input  logic [ELEM_W-1:0]       cfg_clip,
    relu_stream_engine_if.master    bus,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W+LANES-1:0] neg_cnt
);
    localparam int unsigned DATA_W = ELEM_W * LANES;
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned NEG_W  = ADDR_W + LANES;
    localparam int unsigned PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_D + 1);
    localparam int unsigned CRD_W  = $clog2(FIFO_D + RD_LAT + 2) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_RELU,
        M_LEAKY,
        M_CLAMP,
        M_PASS
    } mode_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    mode_t             r_mode;
    logic [3:0]        r_shift;
    logic [ELEM_W-1:0] r_clip;

    logic [LEN_W-1:0]  r_rd_cnt;
    logic [LEN_W-1:0]  r_wr_cnt;
    logic [RD_LAT-1:0] r_vld_sr;
    logic              r_act_vld;
    logic [DATA_W-1:0] r_act_data;
    logic [NEG_W-1:0]  r_neg_cnt;

    logic [DATA_W-1:0] r_mem [FIFO_D];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_src_ren;
    logic              w_dst_wen;
    logic              w_ret;
    logic              w_push;
    logic              w_pop;
    logic              w_start_ok;
    logic              w_credit_ok;
    logic              w_rd_more;
    logic              w_rd_last;
    logic              w_wr_done;
    logic [CRD_W-1:0]  w_inflight;
    logic [DATA_W-1:0] w_act;
    logic [NEG_W-1:0]  w_neg_add;

    function automatic logic [ELEM_W-1:0] act_lane(
        input logic signed [ELEM_W-1:0] x,
        input mode_t                    mode,
        input logic [3:0]               sh,
        input logic signed [ELEM_W-1:0] clip
    );
        logic [ELEM_W-1:0] y;
        y = x;
        case (mode)
            M_RELU:  y = x[ELEM_W-1] ? '0 : x;
            M_LEAKY: y = x[ELEM_W-1] ? (x >>> sh) : x;
            M_CLAMP: begin
                if (clip[ELEM_W-1] || x[ELEM_W-1]) y = '0;
                else if (x > clip)                 y = clip;
                else                               y = x;
            end
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_ret      = r_vld_sr[RD_LAT-1];
    assign w_push     = r_act_vld;
    assign w_dst_wen  = (r_count != '0);
    assign w_pop      = w_dst_wen && bus.dst_ready;
    assign w_rd_more  = (r_rd_cnt < r_len);
    assign w_rd_last  = ((r_rd_cnt + LEN_W'(1)) == r_len);
    assign w_wr_done  = ((r_wr_cnt + LEN_W'(w_pop)) == r_len);

    // Reads in the shift register or the activation register already own a FIFO slot.
    always_comb begin
        w_inflight = CRD_W'(r_act_vld);
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CRD_W'(r_vld_sr[i]);
        end
    end

    assign w_credit_ok = ((CRD_W'(r_count) + w_inflight) < CRD_W'(FIFO_D));

    always_comb begin
        w_act     = '0;
        w_neg_add = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_act[i*ELEM_W +: ELEM_W] = act_lane(bus.src_rdata[i*ELEM_W +: ELEM_W],
                                                 r_mode, r_shift, r_clip);
            w_neg_add = w_neg_add + NEG_W'(bus.src_rdata[i*ELEM_W + ELEM_W - 1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // DRAIN looks ahead at the final pop so done lands the cycle after the last write;
    // a zero-length job passes through DRAIN for one cycle with nothing to wait for.
    always_comb begin
        w_state_nxt = r_state;
        w_src_ren   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = (cfg_len == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                w_src_ren = w_rd_more && w_credit_ok;
                if (w_src_ren && w_rd_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_wr_done) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_mode     <= M_RELU;
            r_shift    <= '0;
            r_clip     <= '0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_vld_sr   <= '0;
            r_act_vld  <= 1'b0;
            r_act_data <= '0;
            r_neg_cnt  <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_vld_sr  <= (r_vld_sr << 1) | RD_LAT'(w_src_ren);
            r_act_vld <= w_ret;
            if (w_ret) r_act_data <= w_act;
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            if (w_start_ok) begin
                r_len     <= cfg_len;
                r_src     <= cfg_src;
                r_dst     <= cfg_dst;
                r_mode    <= mode_t'(cfg_mode);
                r_shift   <= cfg_shift;
                r_clip    <= cfg_clip;
                r_rd_cnt  <= '0;
                r_wr_cnt  <= '0;
                r_neg_cnt <= '0;
            end else begin
                if (w_src_ren) r_rd_cnt <= r_rd_cnt + LEN_W'(1);
                if (w_pop)     r_wr_cnt <= r_wr_cnt + LEN_W'(1);
                if (w_ret)     r_neg_cnt <= r_neg_cnt + w_neg_add;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= r_act_data;
    end

    assign bus.src_ren   = w_src_ren;
    assign bus.src_addr  = w_src_ren ? (r_src + r_rd_cnt[ADDR_W-1:0]) : '0;
    assign bus.dst_wen   = w_dst_wen;
    assign bus.dst_addr  = w_dst_wen ? (r_dst + r_wr_cnt[ADDR_W-1:0]) : '0;
    assign bus.dst_wdata = w_dst_wen ? r_mem[r_rptr] : '0;
    assign neg_cnt       = r_neg_cnt;
endmodule

// File: tb/tb_relu_stream_engine.sv
// Directed bench for relu_stream_engine: activation modes, latency, back-pressure,
// address wrap, zero length, ignored start and mid-job reset.
module tb_relu_stream_engine;
    localparam int unsigned ELEM_W = 16;
    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned FIFO_D = 4;
    localparam int unsigned DATA_W = ELEM_W * LANES;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [ADDR_W:0]         cfg_len;
    logic [ADDR_W-1:0]       cfg_src;
    logic [ADDR_W-1:0]       cfg_dst;
    logic [1:0]              cfg_mode;
    logic [3:0]              cfg_shift;
    logic [ELEM_W-1:0]       cfg_clip;
    logic                    busy;
    logic                    done;
    logic [ADDR_W+LANES-1:0] neg_cnt;

    relu_stream_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    relu_stream_engine #(
        .ELEM_W(ELEM_W),
        .LANES (LANES),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT),
        .FIFO_D(FIFO_D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_len  (cfg_len),
        .cfg_src  (cfg_src),
        .cfg_dst  (cfg_dst),
        .cfg_mode (cfg_mode),
        .cfg_shift(cfg_shift),
        .cfg_clip (cfg_clip),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .neg_cnt  (neg_cnt)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] smem [1024];
    logic              s_ren = 1'b0;
    logic [ADDR_W-1:0] s_addr = '0;
    logic              rnd_en = 1'b0;
    logic              rnd_bit = 1'b1;
    int                cyc = 0;

    // Source SRAM with one cycle of read latency; destination ready 1-in-3 when randomised.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rnd_bit <= ($urandom_range(0, 2) == 0);
        if (s_ren) bus.src_rdata <= smem[s_addr];
    end
    assign bus.dst_ready = rnd_en ? rnd_bit : 1'b1;

    logic [ADDR_W-1:0] ra_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];
    int                rc_q[$];
    int                wc_q[$];
    int                n_done = 0;
    int                done_cyc = 0;
    int                stall_err = 0;
    int                job_rd = 0;
    int                job_wr = 0;
    int                max_occ = 0;
    logic              p_stall = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [DATA_W-1:0] p_data = '0;

    always @(negedge clk) begin
        s_ren  = bus.src_ren;
        s_addr = bus.src_addr;
        if (start && !busy && !done && !rst) begin
            job_rd = 0;
            job_wr = 0;
        end
        if (bus.src_ren) begin
            ra_q.push_back(bus.src_addr);
            rc_q.push_back(cyc);
            job_rd++;
        end
        if (bus.dst_wen && bus.dst_ready) begin
            wa_q.push_back(bus.dst_addr);
            wd_q.push_back(bus.dst_wdata);
            wc_q.push_back(cyc);
            job_wr++;
        end
        if (p_stall && (!bus.dst_wen || bus.dst_addr !== p_addr || bus.dst_wdata !== p_data))
            stall_err++;
        p_stall = bus.dst_wen && !bus.dst_ready && !rst;
        p_addr  = bus.dst_addr;
        p_data  = bus.dst_wdata;
        if (job_rd - job_wr > max_occ) max_occ = job_rd - job_wr;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int start_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DATA_W-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic launch(input int len, input int src, input int dst, input int mode,
                          input int sh, input int clip);
        cfg_len   = len[ADDR_W:0];
        cfg_src   = src[ADDR_W-1:0];
        cfg_dst   = dst[ADDR_W-1:0];
        cfg_mode  = mode[1:0];
        cfg_shift = sh[3:0];
        cfg_clip  = clip[ELEM_W-1:0];
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int db, input int budget);
        int k = 0;
        while (n_done == db && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("done_once", 64'(n_done - db), 64'd1);
    endtask

    int db, rb, wb, se, bad;

    initial begin
        rst = 1'b1; start = 1'b0;
        cfg_len = '0; cfg_src = '0; cfg_dst = '0; cfg_mode = '0; cfg_shift = '0; cfg_clip = '0;
        for (int i = 0; i < 1024; i++) smem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ren", 64'(bus.src_ren), 64'd0);
        chk("rst_wen", 64'(bus.dst_wen), 64'd0);
        chk("rst_neg", 64'(neg_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ReLU, three identical words
        for (int i = 0; i < 3; i++) smem[i] = pk(-1, 2, -32768, 7);
        db = n_done; wb = wa_q.size();
        launch(3, 0, 100, 0, 0, 0);
        wait_done(db, 60);
        chk("t1_nwr", 64'(wa_q.size() - wb), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_data", wd_q[wb+i], pk(0, 2, 0, 7));
            chk("t1_addr", 64'(wa_q[wb+i]), 64'(100 + i));
        end
        chk("t1_neg", 64'(neg_cnt), 64'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_neg_hold", 64'(neg_cnt), 64'd6);
        chk("t1_single_done", 64'(n_done - db), 64'd1);

        // Leaky with shift 2, also len=1 latency
        smem[10] = pk(-8, -1, 5, -32768);
        db = n_done; rb = ra_q.size(); wb = wa_q.size();
        launch(1, 10, 110, 1, 2, 0);
        wait_done(db, 60);
        chk("t2_data", wd_q[wb], pk(-2, -1, 5, -8192));
        chk("t2_ren_lat", 64'(rc_q[rb] - start_cyc), 64'd1);
        chk("t2_wen_lat", 64'(wc_q[wb] - start_cyc), 64'd4);
        chk("t2_done_lat", 64'(done_cyc - start_cyc), 64'd5);
        chk("t2_neg", 64'(neg_cnt), 64'd3);

        // Clamp with clip 6, clip -1, then pass
        smem[20] = pk(-3, 4, 6, 100);
        db = n_done; wb = wa_q.size();
        launch(1, 20, 120, 2, 0, 6);
        wait_done(db, 60);
        chk("t3_clamp6", wd_q[wb], pk(0, 4, 6, 6));
        db = n_done; wb = wa_q.size();
        launch(1, 20, 121, 2, 0, -1);
        wait_done(db, 60);
        chk("t3_clampneg", wd_q[wb], 64'd0);
        db = n_done; wb = wa_q.size();
        launch(1, 20, 122, 3, 0, 0);
        wait_done(db, 60);
        chk("t3_pass", wd_q[wb], pk(-3, 4, 6, 100));
        chk("t3_neg", 64'(neg_cnt), 64'd1);

        // Back-pressure: 16 ReLU words, ready high 1 cycle in 3
        for (int i = 0; i < 16; i++) smem[200+i] = pk(i, -i, 1000 + i, -5);
        db = n_done; wb = wa_q.size(); se = stall_err;
        rnd_en = 1'b1;
        launch(16, 200, 300, 0, 0, 0);
        wait_done(db, 600);
        rnd_en = 1'b0;
        chk("t4_nwr", 64'(wa_q.size() - wb), 64'd16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (wd_q[wb+i] !== pk(i, 0, 1000 + i, 0)) bad++;
            if (wa_q[wb+i] !== 10'(300 + i)) bad++;
        end
        chk("t4_order", 64'(bad), 64'd0);
        chk("t4_stall_stable", 64'(stall_err - se), 64'd0);
        chk("t4_occupancy", 64'(max_occ <= FIFO_D), 64'd1);
        chk("t4_neg", 64'(neg_cnt), 64'd31);

        // Address wrap on both sides
        smem[1022] = pk(1, -2, 3, -4);
        smem[1023] = pk(5, 6, 7, 8);
        smem[0]    = pk(-9, 10, -11, 12);
        smem[1]    = pk(13, 14, 15, -16);
        db = n_done; rb = ra_q.size(); wb = wa_q.size();
        launch(4, 1022, 1020, 3, 0, 0);
        wait_done(db, 60);
        chk("t5_raddr0", 64'(ra_q[rb]),   64'd1022);
        chk("t5_raddr1", 64'(ra_q[rb+1]), 64'd1023);
        chk("t5_raddr2", 64'(ra_q[rb+2]), 64'd0);
        chk("t5_raddr3", 64'(ra_q[rb+3]), 64'd1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (wa_q[wb+i] !== 10'(1020 + i)) bad++;
        end
        if (wd_q[wb]   !== pk(1, -2, 3, -4))     bad++;
        if (wd_q[wb+1] !== pk(5, 6, 7, 8))       bad++;
        if (wd_q[wb+2] !== pk(-9, 10, -11, 12))  bad++;
        if (wd_q[wb+3] !== pk(13, 14, 15, -16))  bad++;
        chk("t5_writes", 64'(bad), 64'd0);

        // Zero length
        db = n_done; rb = ra_q.size(); wb = wa_q.size();
        launch(0, 5, 5, 0, 0, 0);
        wait_done(db, 20);
        chk("t5_len0_lat", 64'(done_cyc - start_cyc), 64'd2);
        chk("t5_len0_noren", 64'(ra_q.size() - rb), 64'd0);
        chk("t5_len0_nowen", 64'(wa_q.size() - wb), 64'd0);

        // Start during RUN is ignored
        for (int i = 0; i < 8; i++) smem[400+i] = pk(i + 1, -1, 2, 3);
        db = n_done; wb = wa_q.size();
        launch(8, 400, 500, 0, 0, 0);
        chk("t6_busy", 64'(busy), 64'd1);
        launch(1, 20, 900, 3, 0, 0);
        wait_done(db, 100);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_nwr", 64'(wa_q.size() - wb), 64'd8);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (wa_q[wb+i] !== 10'(500 + i)) bad++;
            if (wd_q[wb+i] !== pk(i + 1, 0, 2, 3)) bad++;
        end
        chk("t6_ignored_start", 64'(bad), 64'd0);
        chk("t6_neg", 64'(neg_cnt), 64'd8);

        // Reset mid-job
        db = n_done;
        launch(8, 400, 600, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_ren", 64'(bus.src_ren), 64'd0);
        chk("t6_rst_wen", 64'(bus.dst_wen), 64'd0);
        chk("t6_rst_neg", 64'(neg_cnt), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("t6_rst_nodone", 64'(n_done - db), 64'd0);

        // Fresh job after the abort
        db = n_done; wb = wa_q.size();
        launch(2, 400, 700, 0, 0, 0);
        wait_done(db, 60);
        chk("t6_post_nwr", 64'(wa_q.size() - wb), 64'd2);
        chk("t6_post_d0", wd_q[wb],   pk(1, 0, 2, 3));
        chk("t6_post_d1", wd_q[wb+1], pk(2, 0, 2, 3));
        chk("t6_post_a0", 64'(wa_q[wb]), 64'd700);
        chk("t6_post_neg", 64'(neg_cnt), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
